// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the ROM and
// queues {instr, pc} pairs for decode over a valid/ready handshake.
module fetch_ctrl #(
    parameter int N     = 64,
    parameter int IW    = 32,
    parameter int DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic [5:0]    imem_addr,
    input  logic [IW-1:0] imem_q,
    input  logic          redirect_valid,
    input  logic [N-1:0]  redirect_pc,
    output logic          instr_valid,
    input  logic          instr_ready,
    output logic [IW-1:0] instr,
    output logic [N-1:0]  instr_pc,
    output logic          halted,
    output logic          fault
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] HALT  = 2'd2;
    localparam logic [1:0] FAULT = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic [N-1:0]  fetch_pc;

    logic [IW-1:0] q_instr [DEPTH];
    logic [N-1:0]  q_pc    [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] count;

    logic in_range;
    logic tgt_in_range;
    logic redir_bad;
    logic redir_ok;
    logic redir_take;
    logic full;
    logic empty;
    logic pop;
    logic push;
    logic flush;

    assign in_range     = (fetch_pc[N-1:8] == '0) && (fetch_pc[1:0] == 2'b00);
    assign tgt_in_range = (redirect_pc[N-1:8] == '0);
    assign redir_bad    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign redir_ok     = redirect_valid && (redirect_pc[1:0] == 2'b00);
    // FAULT is terminal: redirects no longer move the PC.
    assign redir_take   = redirect_valid && (state != FAULT);

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign pop   = instr_valid && instr_ready;
    assign push  = (state == RUN) && !redirect_valid && in_range
                   && (!full || pop);
    assign flush = redirect_valid || (state == FAULT);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (redir_bad)
                    state_nx = FAULT;
                else if (start && !redirect_valid)
                    state_nx = RUN;
            end
            RUN: begin
                if (redir_bad)
                    state_nx = FAULT;
                else if (!redirect_valid && !in_range)
                    state_nx = HALT;
            end
            HALT: begin
                if (redir_bad)
                    state_nx = FAULT;
                else if (redir_ok && tgt_in_range)
                    state_nx = RUN;
            end
            default: state_nx = FAULT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fetch_pc <= '0;
        else if (redir_take)
            fetch_pc <= redirect_pc;
        else if (push)
            fetch_pc <= fetch_pc + N'(4);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + AW'(1);
            if (pop)
                head <= head + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[tail] <= imem_q;
            q_pc[tail]    <= fetch_pc;
        end
    end

    assign imem_addr   = fetch_pc[7:2];
    assign instr_valid = !empty && (state != FAULT);
    assign instr       = instr_valid ? q_instr[head] : '0;
    assign instr_pc    = instr_valid ? q_pc[head] : '0;
    assign halted      = (state == HALT);
    assign fault       = (state == FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a combinational 64-word ROM model.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic [5:0]  imem_addr;
    logic [31:0] imem_q;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        halted;
    logic        fault;

    logic [31:0] rom [64];
    int vectors;
    int miscompares;

    fetch_ctrl #(.N(64), .IW(32), .DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .imem_addr(imem_addr),
        .imem_q(imem_q),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .instr_pc(instr_pc),
        .halted(halted),
        .fault(fault)
    );

    assign imem_q = rom[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic check_head(input string name, input logic v,
                              input logic [31:0] i, input logic [63:0] p);
        vectors++;
        if ({instr_valid, instr, instr_pc} !== {v, i, p}) begin
            $display("FAIL %s: got v=%0b i=%h pc=%h want v=%0b i=%h pc=%h",
                     name, instr_valid, instr, instr_pc, v, i, p);
            miscompares++;
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        start = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        instr_ready = 1'b0;
        #2;
        vectors++;
        if ({instr_valid, instr, instr_pc, halted, fault, imem_addr} !== '0) begin
            $display("FAIL reset_outputs: got v=%0b i=%h pc=%h h=%0b f=%0b a=%0d want all 0",
                     instr_valid, instr, instr_pc, halted, fault, imem_addr);
            miscompares++;
        end
        do_reset();
        vectors++;
        if ({instr_valid, halted, fault, imem_addr} !== '0) begin
            $display("FAIL reset_idle: got v=%0b h=%0b f=%0b a=%0d want all 0",
                     instr_valid, halted, fault, imem_addr);
            miscompares++;
        end
    endtask

    task automatic test_stream;
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_head("stream_c1", 1'b0, 32'h0, 64'h0);
        tick();
        check_head("stream_c2", 1'b1, 32'hf8000001, 64'h0);
        tick();
        check_head("stream_c3", 1'b1, 32'hf8008002, 64'h4);
        tick();
        check_head("stream_c4", 1'b1, 32'hf8000203, 64'h8);
    endtask

    task automatic test_backpressure;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        vectors++;
        if (imem_addr !== 6'd2) begin
            $display("FAIL bp_addr: got %0d want 2", imem_addr);
            miscompares++;
        end
        check_head("bp_hold", 1'b1, 32'hf8000001, 64'h0);
        instr_ready = 1'b1;
        tick();
        check_head("bp_rel1", 1'b1, 32'hf8008002, 64'h4);
        tick();
        check_head("bp_rel2", 1'b1, 32'hf8000203, 64'h8);
        tick();
        check_head("bp_rel3", 1'b1, 32'h1000_0003, 64'hc);
    endtask

    task automatic test_redirect;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_head("redir_full", 1'b1, 32'hf8000001, 64'h0);
        redirect_valid = 1'b1;
        redirect_pc = 64'h74;
        tick();
        redirect_valid = 1'b0;
        check_head("redir_flushed", 1'b0, 32'h0, 64'h0);
        vectors++;
        if (imem_addr !== 6'd29) begin
            $display("FAIL redir_addr: got %0d want 29", imem_addr);
            miscompares++;
        end
        tick();
        check_head("redir_target", 1'b1, 32'hb4000040, 64'h74);
        instr_ready = 1'b1;
        tick();
        check_head("redir_next", 1'b1, 32'h1000_001e, 64'h78);
    endtask

    task automatic test_halt;
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 64'hf8;
        tick();
        redirect_valid = 1'b0;
        tick();
        check_head("halt_f8", 1'b1, 32'h0, 64'hf8);
        tick();
        check_head("halt_fc", 1'b1, 32'h0, 64'hfc);
        tick();
        vectors++;
        if ({instr_valid, halted} !== 2'b01) begin
            $display("FAIL halt_state: got v=%0b h=%0b want v=0 h=1",
                     instr_valid, halted);
            miscompares++;
        end
        redirect_valid = 1'b1;
        redirect_pc = 64'h0;
        tick();
        redirect_valid = 1'b0;
        vectors++;
        if (halted !== 1'b0) begin
            $display("FAIL halt_resume: got h=%0b want 0", halted);
            miscompares++;
        end
        tick();
        check_head("halt_refetch", 1'b1, 32'hf8000001, 64'h0);
    endtask

    task automatic test_fault;
        do_reset();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        redirect_valid = 1'b1;
        redirect_pc = 64'h6;
        tick();
        vectors++;
        if ({fault, instr_valid, halted} !== 3'b100) begin
            $display("FAIL fault_enter: got f=%0b v=%0b h=%0b want f=1 v=0 h=0",
                     fault, instr_valid, halted);
            miscompares++;
        end
        start = 1'b1;
        redirect_pc = 64'h0;
        repeat (3) tick();
        vectors++;
        if ({fault, instr_valid, halted} !== 3'b100) begin
            $display("FAIL fault_sticky: got f=%0b v=%0b h=%0b want f=1 v=0 h=0",
                     fault, instr_valid, halted);
            miscompares++;
        end
        start = 1'b0;
        redirect_valid = 1'b0;
        reset = 1'b1;
        #1;
        vectors++;
        if (fault !== 1'b0) begin
            $display("FAIL fault_clear: got %0b want 0", fault);
            miscompares++;
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_async_reset;
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check_head("areset_full", 1'b1, 32'hf8000001, 64'h0);
        #3;
        reset = 1'b1;
        #1;
        vectors++;
        if ({instr_valid, instr, instr_pc, halted, fault, imem_addr} !== '0) begin
            $display("FAIL areset_async: got v=%0b i=%h pc=%h h=%0b f=%0b a=%0d want all 0",
                     instr_valid, instr, instr_pc, halted, fault, imem_addr);
            miscompares++;
        end
        tick();
        reset = 1'b0;
        tick();
        check_head("areset_idle", 1'b0, 32'h0, 64'h0);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_head("areset_refetch", 1'b1, 32'hf8000001, 64'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int k = 0; k < 64; k++)
            rom[k] = 32'h1000_0000 + 32'(k);
        rom[0]  = 32'hf8000001;
        rom[1]  = 32'hf8008002;
        rom[2]  = 32'hf8000203;
        rom[29] = 32'hb4000040;
        rom[62] = 32'h0;
        rom[63] = 32'h0;

        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_fault();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
